// File: rtl/pipe_pkg.sv
// Shared defaults for the M/W pipeline register slice.
// Imported by the writeback stage and its helper logic.
package pipe_pkg;

  localparam int LANES_DEF = 2;
  localparam int DW_DEF    = 32;
  localparam int RW_DEF    = 5;
  localparam int CW_DEF    = 32;
  localparam int ZERO_REG  = 0;

endpackage

// File: rtl/pipemw_conflict.sv
// Same-destination squash mask for the W stage.
// Older lane loses to any younger lane writing the same register.
module pipemw_conflict
  import pipe_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int RW    = RW_DEF
) (
  input  logic [LANES-1:0]    qual,
  input  logic [LANES*RW-1:0] writereg,
  output logic [LANES-1:0]    squash
);

  always_comb begin
    squash = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (qual[i] && qual[j] &&
            writereg[i*RW +: RW] == writereg[j*RW +: RW])
          squash[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipemw_nway.sv
// Multi-lane M->W pipeline register with writeback mux,
// register-write qualification and retired-instruction counter.
module pipemw_nway
  import pipe_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DW    = DW_DEF,
  parameter int RW    = RW_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallw,
  input  logic                flushw,
  input  logic [LANES-1:0]    validm,
  input  logic [LANES-1:0]    memtoregm,
  input  logic [LANES-1:0]    regwritem,
  input  logic [LANES*DW-1:0] readdatam,
  input  logic [LANES*DW-1:0] aluoutm,
  input  logic [LANES*RW-1:0] writeregm,
  output logic [LANES-1:0]    validw,
  output logic [LANES-1:0]    memtoregw,
  output logic [LANES-1:0]    regwritew,
  output logic [LANES*DW-1:0] readdataw,
  output logic [LANES*DW-1:0] aluoutw,
  output logic [LANES*RW-1:0] writeregw,
  output logic [LANES*DW-1:0] resultw,
  output logic [CW-1:0]       retiredw
);

  function automatic logic [CW-1:0] popcount(
    input logic [LANES-1:0] v
  );
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++)
      c = c + CW'(v[i]);
    return c;
  endfunction

  logic [LANES-1:0] qual;
  logic [LANES-1:0] squash;

  always_comb begin
    qual = '0;
    for (int i = 0; i < LANES; i++)
      qual[i] = validm[i] & regwritem[i] &
                (writeregm[i*RW +: RW] != RW'(ZERO_REG));
  end

  pipemw_conflict #(
    .LANES (LANES),
    .RW    (RW)
  ) u_conflict (
    .qual     (qual),
    .writereg (writeregm),
    .squash   (squash)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      validw    <= '0;
      memtoregw <= '0;
      regwritew <= '0;
      readdataw <= '0;
      aluoutw   <= '0;
      writeregw <= '0;
      retiredw  <= '0;
    end else if (stallw) begin
      validw    <= validw;
      memtoregw <= memtoregw;
      regwritew <= regwritew;
      retiredw  <= retiredw;
    end else if (flushw) begin
      // Bubble: control cleared, payload left as-is.
      validw    <= '0;
      memtoregw <= '0;
      regwritew <= '0;
    end else begin
      validw    <= validm;
      memtoregw <= memtoregm & validm;
      regwritew <= qual & ~squash;
      readdataw <= readdatam;
      aluoutw   <= aluoutm;
      writeregw <= writeregm;
      retiredw  <= retiredw + popcount(validm);
    end
  end

  always_comb begin
    resultw = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!rst)
        resultw[i*DW +: DW] = memtoregw[i] ?
          readdataw[i*DW +: DW] : aluoutw[i*DW +: DW];
    end
  end

endmodule

// File: doc/pipemw_nway.md
PIPEMW_NWAY -- requirements
Module: pipemw_nway

Interface
REQ-001 Parameter LANES, default 2: number of issue lanes carried; legal 1..4.
REQ-002 Parameter DW, default 32: data width of readdata/aluout/result.
REQ-003 Parameter RW, default 5: register-address width.
REQ-004 Parameter CW, default 32: retired-instruction counter width.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 stallw  in  1  hold all W-stage registers and counter.
REQ-008 flushw  in  1  load bubble: clear all W-stage valid/control bits.
REQ-009 validm  in  LANES  per-lane M-stage instruction valid.
REQ-010 memtoregm  in  LANES  per-lane select: 1 = readdata, 0 = aluout.
REQ-011 regwritem  in  LANES  per-lane register-write enable.
REQ-012 readdatam  in  LANES*DW  per-lane memory read data; lane i at bits [i*DW +: DW].
REQ-013 aluoutm  in  LANES*DW  per-lane ALU result, same packing.
REQ-014 writeregm  in  LANES*RW  per-lane destination register, lane i at [i*RW +: RW].
REQ-015 validw, memtoregw, regwritew  out  LANES each  registered W-stage copies (regwritew qualified per REQ-021..023).
REQ-016 readdataw, aluoutw  out  LANES*DW  registered data.
REQ-017 writeregw  out  LANES*RW  registered destination.
REQ-018 resultw  out  LANES*DW  combinational per-lane writeback value: memtoregw ? readdataw : aluoutw.
REQ-019 retiredw  out  CW  running count of valid instructions loaded into W.

Function
REQ-020 Priority per edge: rst > stallw > flushw > normal load; stallw with flushw holds (no flush).
REQ-021 Normal load: latency 1 cycle; every W register takes its M input; regwritew[i] = validm[i] & regwritem[i] & (writeregm[i] != 0).
REQ-022 Destination to register 0 never asserts regwritew; data still latched.
REQ-023 Same-destination conflict: if lanes i<j both qualify per REQ-021 with equal writeregm, regwritew[i] cleared (younger lane j wins); applies across all pairs; lane LANES-1 never squashed.
REQ-024 Squashed lane keeps validw=1 and is counted by retiredw.
REQ-025 Flush: validw, regwritew, memtoregw all 0; data/writereg registers hold previous values; retiredw unchanged.
REQ-026 Stall: every output register and retiredw hold; resultw follows held values.
REQ-027 retiredw increments on normal load by popcount(validm), modulo 2^CW (wraps to low bits, no saturation).
REQ-028 validm[i]=0 forces regwritew[i]=0 and memtoregw[i]=0 regardless of other inputs.
REQ-029 LANES=1: conflict logic absent; behaviour otherwise identical.

Reset
REQ-030 rst=1 at an edge: all registered outputs and retiredw to 0, regardless of stallw/flushw.
REQ-031 Reset mid-stall clears state; first edge after rst deasserts performs a normal load/stall/flush per REQ-020.
REQ-032 No output X after first reset edge; resultw = 0 while in reset.

Structure
REQ-033 Shared package pipe_pkg holds defaults LANES_DEF, DW_DEF, RW_DEF, CW_DEF and ZERO_REG constant (0).
REQ-034 One sub-module pipemw_conflict: combinational, inputs qualified regwrite vector and writereg vector, outputs squash mask; instantiated once.
REQ-035 Popcount implemented as a function inside pipemw_nway; no other sub-modules.

Verification
REQ-036 Reset: rst=1 with all M inputs 1s -> next edge every output 0, retiredw=0, resultw=0.
REQ-037 Dual load: validm=11, regwritem=11, writeregm lane0=3 lane1=7, memtoregm=01, readdatam lane0=0xAAAA0000, aluoutm lane1=0x1234 -> regwritew=11, resultw lane0=0xAAAA0000, lane1=0x1234, retiredw+2.
REQ-038 Conflict: both lanes writeregm=9, regwritem=11, validm=11 -> regwritew=10, validw=11, retiredw+2.
REQ-039 Zero register: lane0 writeregm=0, regwritem=1 -> regwritew[0]=0, aluoutw lane0 latched.
REQ-040 Stall/flush: stallw=1 and flushw=1 for 2 edges -> outputs and retiredw unchanged; then flushw=1 alone -> validw=00, regwritew=00, retiredw unchanged.
REQ-041 Wrap: CW=4, preload retiredw=15 via loads, one load with validm=11 -> retiredw=1.
